programmable_clock_divider: RTL and testbench

PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

---
 rtl/programmable_clock_divider_if.sv | 12 +
 rtl/programmable_clock_divider.sv | 48 ++++
 tb/tb_programmable_clock_divider.sv | 129 ++++++++++++
 3 files changed

// File: rtl/programmable_clock_divider_if.sv
// programmable_clock_divider_if: control and status bundle for the programmable clock divider
interface programmable_clock_divider_if #(parameter int WIDTH = 28);
  logic enable;
  logic div_load;
  logic [WIDTH-1:0] div_in;
  logic clock_out;
  logic [WIDTH-1:0] div_active;
  logic load_pending;
  logic tick;
  modport master (output enable, div_load, div_in, input clock_out, div_active, load_pending, tick);
  modport slave (input enable, div_load, div_in, output clock_out, div_active, load_pending, tick);
endinterface

// File: rtl/programmable_clock_divider.sv
// programmable_clock_divider: glitch-free divide-by-N with wrap-aligned divisor reloads; tick pulse when CLKDIV_TICK_EN is defined
module programmable_clock_divider #(
  parameter int WIDTH = 28,
  parameter int DEFAULT_DIV = 2
) (
  input logic clock_in,
  input logic reset,
  programmable_clock_divider_if.slave bus
);
  localparam logic [WIDTH-1:0] DEF_DIV = DEFAULT_DIV < 2 ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);
  logic [WIDTH-1:0] count, count_nx, active, active_nx, shadow, shadow_nx;
  logic out_q, out_nx, pend, pend_nx, wrap, apply;
  // a load landing on the wrap edge supersedes the older pending value, so nothing is applied there
  always_comb begin
    wrap = bus.enable && count == active - WIDTH'(1);
    apply = wrap && pend && !bus.div_load;
    count_nx = !bus.enable ? count : wrap ? '0 : count + WIDTH'(1);
    active_nx = apply ? shadow : active;
    out_nx = bus.enable ? count_nx < (active_nx >> 1) : out_q;
    shadow_nx = !bus.div_load ? shadow : bus.div_in < WIDTH'(2) ? WIDTH'(2) : bus.div_in;
    pend_nx = bus.div_load || (pend && !apply);
  end
  always_ff @(posedge clock_in) begin
    if (reset) begin
      count <= '0;
      out_q <= 1'b0;
      active <= DEF_DIV;
      shadow <= DEF_DIV;
      pend <= 1'b0;
    end else begin
      count <= count_nx;
      out_q <= out_nx;
      active <= active_nx;
      shadow <= shadow_nx;
      pend <= pend_nx;
    end
  end
  assign bus.clock_out = out_q;
  assign bus.div_active = active;
  assign bus.load_pending = pend;
`ifdef CLKDIV_TICK_EN
  logic tick_q;
  always_ff @(posedge clock_in) tick_q <= reset ? 1'b0 : wrap;
  assign bus.tick = tick_q;
`else
  assign bus.tick = 1'b0;
`endif
endmodule

// File: tb/tb_programmable_clock_divider.sv
// tb_programmable_clock_divider: directed vectors feeding a scoreboard queue, checked by an independent monitor
module tb_programmable_clock_divider;
  localparam int W = 8;
`ifdef CLKDIV_TICK_EN
  localparam bit TICK_EN = 1'b1;
`else
  localparam bit TICK_EN = 1'b0;
`endif
  typedef struct packed {
    logic clk;
    logic [W-1:0] act;
    logic pend;
    logic tk;
  } exp_t;
  logic clock_in = 1'b0;
  logic reset = 1'b0;
  exp_t sb[$];
  exp_t want, got;
  int errors = 0;
  int checks = 0;
  always #5 clock_in = ~clock_in;
  programmable_clock_divider_if #(.WIDTH(W)) bus ();
  programmable_clock_divider #(.WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clock_in(clock_in),
    .reset(reset),
    .bus(bus)
  );
  task automatic step(input logic r, input logic e, input logic l, input int d,
                      input logic c, input int a, input logic p, input logic t);
    exp_t x;
    @(negedge clock_in);
    reset = r;
    bus.enable = e;
    bus.div_load = l;
    bus.div_in = W'(d);
    x.clk = c;
    x.act = W'(a);
    x.pend = p;
    x.tk = TICK_EN ? t : 1'b0;
    sb.push_back(x);
  endtask
  initial begin
    forever begin
      @(posedge clock_in);
      #1;
      if (sb.size() > 0) begin
        want = sb.pop_front();
        got = {bus.clock_out, bus.div_active, bus.load_pending, bus.tick};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL vec%0d: got clk=%b act=%0d pend=%b tick=%b, want clk=%b act=%0d pend=%b tick=%b",
                   checks, got.clk, got.act, got.pend, got.tk, want.clk, want.act, want.pend, want.tk);
        end
      end
    end
  end
  initial begin
    bus.enable = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in = '0;
    // reset, and reset overriding enable/load
    step(1,0,0,0, 0,2,0,0);
    step(1,1,1,9, 0,2,0,0);
    // default divide-by-2
    step(0,1,0,0, 0,2,0,0);
    step(0,1,0,0, 1,2,0,1);
    step(0,1,0,0, 0,2,0,0);
    step(0,1,0,0, 1,2,0,1);
    // load 5 mid-period, applied at wrap
    step(0,1,1,5, 0,2,1,0);
    step(0,1,0,0, 1,5,0,1);
    step(0,1,0,0, 1,5,0,0);
    step(0,1,0,0, 0,5,0,0);
    step(0,1,0,0, 0,5,0,0);
    step(0,1,0,0, 0,5,0,0);
    step(0,1,0,0, 1,5,0,1);
    step(0,1,0,0, 1,5,0,0);
    // 7 then 3: last write wins
    step(0,1,1,7, 0,5,1,0);
    step(0,1,1,3, 0,5,1,0);
    step(0,1,0,0, 0,5,1,0);
    step(0,1,0,0, 1,3,0,1);
    step(0,1,0,0, 0,3,0,0);
    step(0,1,0,0, 0,3,0,0);
    step(0,1,0,0, 1,3,0,1);
    // load on the wrap edge discards the older pending 6; 4 applies one period later
    step(0,1,1,6, 0,3,1,0);
    step(0,1,0,0, 0,3,1,0);
    step(0,1,1,4, 1,3,1,1);
    step(0,1,0,0, 0,3,1,0);
    step(0,1,0,0, 0,3,1,0);
    step(0,1,0,0, 1,4,0,1);
    step(0,1,0,0, 1,4,0,0);
    step(0,1,0,0, 0,4,0,0);
    step(0,1,0,0, 0,4,0,0);
    step(0,1,0,0, 1,4,0,1);
    step(0,1,0,0, 1,4,0,0);
    // load 0 clamps to 2, then freeze for 10 cycles with a load accepted while frozen
    step(0,1,1,0, 0,4,1,0);
    step(0,1,0,0, 0,4,1,0);
    step(0,1,0,0, 1,2,0,1);
    repeat (5) step(0,0,0,0, 1,2,0,0);
    step(0,0,1,6, 1,2,1,0);
    repeat (4) step(0,0,0,0, 1,2,1,0);
    step(0,1,0,0, 0,2,1,0);
    step(0,1,0,0, 1,6,0,1);
    step(0,1,0,0, 1,6,0,0);
    step(0,1,0,0, 1,6,0,0);
    // reset mid-period with a pending load
    step(0,1,1,6, 0,6,1,0);
    step(1,1,0,0, 0,2,0,0);
    step(0,1,0,0, 0,2,0,0);
    step(0,1,0,0, 1,2,0,1);
    // load 1 clamps to 2
    step(0,1,1,1, 0,2,1,0);
    step(0,1,0,0, 1,2,0,1);
    @(negedge clock_in);
    bus.enable = 1'b0;
    repeat (3) @(negedge clock_in);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
